// File: rtl/grf_dump.sv
// Register-file dump engine: freezes the datapath, walks FIRST_REG..LAST_REG and streams (index, value) beats.
// Two cycles per register (READ, SEND); SEND holds its beat until out_ready, skipped zeros cost one cycle.
module grf_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        hold_req,
    input  logic        hold_ack,
    output logic [4:0]  raddr,
    input  logic [31:0] rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum,
    output logic [5:0]  sent_count
);
    localparam logic [4:0] FIRST = FIRST_REG[4:0];
    localparam logic [4:0] LAST  = LAST_REG[4:0];

    typedef enum logic [2:0] {IDLE, REQ, READ, SEND, FIN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_idx;
    logic [4:0]  r_out_addr;
    logic [31:0] r_out_data;
    logic [31:0] r_checksum;
    logic [5:0]  r_sent_count;

    logic        w_last;
    logic        w_skip;
    logic        w_accept;
    logic        w_abort;
    logic        w_hold_req;
    logic        w_out_valid;
    logic        w_busy;
    logic        w_done;
    logic [4:0]  w_raddr;

    assign w_last   = (r_idx == LAST);
    assign w_skip   = SKIP_ZERO && (rdata == 32'd0);
    assign w_accept = (r_state == SEND) && out_ready;
    assign w_abort  = abort && (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode from state only, so an async reset clears them without a clock edge.
    always_comb begin
        w_next      = r_state;
        w_hold_req  = 1'b1;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_raddr     = 5'd0;
        case (r_state)
            IDLE: begin
                w_hold_req = 1'b0;
                w_busy     = 1'b0;
                if (start) w_next = REQ;
            end
            REQ: begin
                if (hold_ack) w_next = READ;
            end
            READ: begin
                w_raddr = r_idx;
                if (!w_skip)     w_next = SEND;
                else if (w_last) w_next = FIN;
            end
            SEND: begin
                w_out_valid = 1'b1;
                if (out_ready) w_next = w_last ? FIN : READ;
            end
            FIN: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx        <= 5'd0;
            r_out_addr   <= 5'd0;
            r_out_data   <= 32'd0;
            r_checksum   <= 32'd0;
            r_sent_count <= 6'd0;
        end else begin
            // A beat accepted in the abort cycle still counts.
            if (w_accept) r_sent_count <= r_sent_count + 6'd1;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_checksum   <= 32'd0;
                        r_sent_count <= 6'd0;
                    end
                end
                REQ: begin
                    if (hold_ack && !abort) r_idx <= FIRST;
                end
                READ: begin
                    if (!abort) begin
                        r_checksum <= r_checksum + rdata;
                        r_out_addr <= r_idx;
                        r_out_data <= rdata;
                        if (w_skip && !w_last) r_idx <= r_idx + 5'd1;
                    end
                end
                SEND: begin
                    if (out_ready && !abort && !w_last) r_idx <= r_idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign hold_req   = w_hold_req;
    assign out_valid  = w_out_valid;
    assign busy       = w_busy;
    assign done       = w_done;
    assign raddr      = w_raddr;
    assign out_addr   = r_out_addr;
    assign out_data   = r_out_data;
    assign checksum   = r_checksum;
    assign sent_count = r_sent_count;
endmodule

// File: tb/tb_grf_dump.sv
// Directed bench for grf_dump: three instances (default, SKIP_ZERO=1, single register 31) share one GRF model.
module tb_grf_dump;
    localparam logic [31:0] K       = 32'h11111111;
    localparam logic [31:0] FULLSUM = 32'h111110F0;  // K * (0+1+...+31) mod 2^32

    logic        clk;
    logic        reset;
    logic        abort;
    logic        hold_ack;
    logic        out_ready;
    logic [2:0]  start;
    logic [2:0]  hold_req;
    logic [2:0]  out_valid;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [4:0]  raddr      [3];
    logic [31:0] rdata      [3];
    logic [4:0]  out_addr   [3];
    logic [31:0] out_data   [3];
    logic [31:0] checksum   [3];
    logic [5:0]  sent_count [3];
    logic [31:0] rf         [32];

    int checks;
    int errors;

    assign rdata[0] = rf[raddr[0]];
    assign rdata[1] = rf[raddr[1]];
    assign rdata[2] = rf[raddr[2]];

    grf_dump #(.FIRST_REG(0), .LAST_REG(31), .SKIP_ZERO(1'b0)) u_full (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort),
        .hold_req(hold_req[0]), .hold_ack(hold_ack), .raddr(raddr[0]), .rdata(rdata[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_addr(out_addr[0]),
        .out_data(out_data[0]), .busy(busy[0]), .done(done[0]),
        .checksum(checksum[0]), .sent_count(sent_count[0]));

    grf_dump #(.FIRST_REG(0), .LAST_REG(31), .SKIP_ZERO(1'b1)) u_skip (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort),
        .hold_req(hold_req[1]), .hold_ack(hold_ack), .raddr(raddr[1]), .rdata(rdata[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_addr(out_addr[1]),
        .out_data(out_data[1]), .busy(busy[1]), .done(done[1]),
        .checksum(checksum[1]), .sent_count(sent_count[1]));

    grf_dump #(.FIRST_REG(31), .LAST_REG(31), .SKIP_ZERO(1'b0)) u_one (
        .clk(clk), .reset(reset), .start(start[2]), .abort(abort),
        .hold_req(hold_req[2]), .hold_ack(hold_ack), .raddr(raddr[2]), .rdata(rdata[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_addr(out_addr[2]),
        .out_data(out_data[2]), .busy(busy[2]), .done(done[2]),
        .checksum(checksum[2]), .sent_count(sent_count[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_ramp();
        for (int i = 0; i < 32; i++) rf[i] = K * i;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 3'b000; abort = 1'b0; hold_ack = 1'b1; out_ready = 1'b1;
        load_ramp();
        #12;
        checks++;
        if ({hold_req, out_valid, busy, done} !== 12'd0 || raddr[0] !== 5'd0 || out_addr[0] !== 5'd0
            || out_data[0] !== 32'd0 || checksum[0] !== 32'd0 || sent_count[0] !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs: hold=%b vld=%b busy=%b done=%b chk=%h cnt=%0d, required all 0",
                     hold_req, out_valid, busy, done, checksum[0], sent_count[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_dump(input bit random_ready);
        int n, beats, done_n, done_cnt;
        bit stalled;
        logic [4:0]  p_addr;
        logic [31:0] p_data;
        load_ramp();
        hold_ack = 1'b1;
        out_ready = random_ready ? 1'b0 : 1'b1;
        beats = 0; done_n = 0; done_cnt = 0; stalled = 1'b0; p_addr = '0; p_data = '0;
        start[0] = 1'b1;
        n = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            start[0] = 1'b0;
            n++;
            if (random_ready) out_ready = ($urandom_range(0, 9) < 3);
            if (stalled) begin
                checks++;
                if (out_valid[0] !== 1'b1 || out_addr[0] !== p_addr || out_data[0] !== p_data) begin
                    errors++;
                    $display("FAIL stall_stable: vld=%b addr=%0d data=%h, required 1 %0d %h",
                             out_valid[0], out_addr[0], out_data[0], p_addr, p_data);
                end
            end
            stalled = out_valid[0] && !out_ready;
            p_addr = out_addr[0];
            p_data = out_data[0];
            if (out_valid[0] && out_ready) begin
                checks++;
                if (out_addr[0] !== beats[4:0] || out_data[0] !== K * beats) begin
                    errors++;
                    $display("FAIL beat_%0d: addr=%0d data=%h, required %0d %h",
                             beats, out_addr[0], out_data[0], beats, K * beats);
                end
                beats++;
            end
            if (done[0]) begin
                done_cnt++;
                done_n = n;
            end
            if (!busy[0]) break;
        end
        checks++;
        if (beats != 32 || sent_count[0] !== 6'd32) begin
            errors++;
            $display("FAIL full_count: beats=%0d sent=%0d, required 32 32", beats, sent_count[0]);
        end
        checks++;
        if (checksum[0] !== FULLSUM) begin
            errors++;
            $display("FAIL full_checksum: got %h, required %h", checksum[0], FULLSUM);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL done_pulses: got %0d, required 1", done_cnt);
        end
        if (!random_ready) begin
            // Cycles counted inclusively from the start cycle through the FIN cycle.
            checks++;
            if (done_n != 67) begin
                errors++;
                $display("FAIL done_latency: got %0d, required 67", done_n);
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_skip_zero();
        int beats;
        logic [4:0]  a [2];
        logic [31:0] d [2];
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[3] = 32'd5;
        rf[31] = 32'hFFFFFFFF;
        out_ready = 1'b1; hold_ack = 1'b1; beats = 0;
        start[1] = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            start[1] = 1'b0;
            if (out_valid[1] && out_ready) begin
                if (beats < 2) begin
                    a[beats] = out_addr[1];
                    d[beats] = out_data[1];
                end
                beats++;
            end
            if (!busy[1]) break;
        end
        checks++;
        if (beats != 2 || sent_count[1] !== 6'd2) begin
            errors++;
            $display("FAIL skip_count: beats=%0d sent=%0d, required 2 2", beats, sent_count[1]);
        end else begin
            checks++;
            if (a[0] !== 5'd3 || d[0] !== 32'd5 || a[1] !== 5'd31 || d[1] !== 32'hFFFFFFFF) begin
                errors++;
                $display("FAIL skip_beats: (%0d,%h) (%0d,%h), required (3,5) (31,ffffffff)",
                         a[0], d[0], a[1], d[1]);
            end
        end
        checks++;
        if (checksum[1] !== 32'd4) begin
            errors++;
            $display("FAIL skip_checksum: got %h, required 4", checksum[1]);
        end
    endtask

    task automatic test_hold_handshake();
        load_ramp();
        hold_ack = 1'b0; out_ready = 1'b1;
        start[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            start[0] = 1'b0;
            checks++;
            if (hold_req[0] !== 1'b1 || raddr[0] !== 5'd0 || out_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL hold_wait_%0d: hold=%b raddr=%0d vld=%b busy=%b, required 1 0 0 1",
                         c, hold_req[0], raddr[0], out_valid[0], busy[0]);
            end
        end
        hold_ack = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (!busy[0]) break;
        end
        checks++;
        if (busy[0] !== 1'b0 || sent_count[0] !== 6'd32 || checksum[0] !== FULLSUM) begin
            errors++;
            $display("FAIL hold_dump: busy=%b sent=%0d chk=%h, required 0 32 %h",
                     busy[0], sent_count[0], checksum[0], FULLSUM);
        end
    endtask

    task automatic test_abort();
        int beats;
        bit seen_done;
        load_ramp();
        hold_ack = 1'b1; out_ready = 1'b1; beats = 0; seen_done = 1'b0;
        start[0] = 1'b1;
        for (int c = 0; c < 100 && beats < 5; c++) begin
            tick();
            start[0] = 1'b0;
            if (out_valid[0] && out_ready) begin
                beats++;
                if (beats == 5) abort = 1'b1;
            end
        end
        tick();
        abort = 1'b0;
        checks++;
        if (sent_count[0] !== 6'd5 || hold_req[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: sent=%0d hold=%b busy=%b done=%b, required 5 0 0 0",
                     sent_count[0], hold_req[0], busy[0], done[0]);
        end
        checks++;
        if (checksum[0] !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL abort_checksum: got %h, required aaaaaaaa", checksum[0]);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done[0]) seen_done = 1'b1;
        end
        checks++;
        if (seen_done || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done_seen=%b busy=%b, required 0 0", seen_done, busy[0]);
        end
    endtask

    task automatic test_async_reset();
        bit got;
        load_ramp();
        hold_ack = 1'b1; out_ready = 1'b0; got = 1'b0;
        start[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            start[0] = 1'b0;
            if (out_valid[0]) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL reset_reach_send: out_valid=%b, required 1", out_valid[0]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (hold_req[0] !== 1'b0 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || out_addr[0] !== 5'd0
            || out_data[0] !== 32'd0 || checksum[0] !== 32'd0 || sent_count[0] !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: hold=%b vld=%b busy=%b data=%h chk=%h, required all 0",
                     hold_req[0], out_valid[0], busy[0], out_data[0], checksum[0]);
        end
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_single_reg();
        bit got;
        load_ramp();
        hold_ack = 1'b1; out_ready = 1'b0; got = 1'b0;
        start[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            start[2] = 1'b0;
            if (out_valid[2]) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || out_addr[2] !== 5'd31 || out_data[2] !== 32'h1111110F) begin
            errors++;
            $display("FAIL single_beat: vld=%b addr=%0d data=%h, required 1 31 1111110f",
                     got, out_addr[2], out_data[2]);
        end
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        checks++;
        if (out_valid[2] !== 1'b1 || out_addr[2] !== 5'd31 || out_data[2] !== 32'h1111110F) begin
            errors++;
            $display("FAIL start_in_send: vld=%b addr=%0d data=%h, required 1 31 1111110f",
                     out_valid[2], out_addr[2], out_data[2]);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (done[2] !== 1'b1 || busy[2] !== 1'b1 || hold_req[2] !== 1'b1) begin
            errors++;
            $display("FAIL single_fin: done=%b busy=%b hold=%b, required 1 1 1", done[2], busy[2], hold_req[2]);
        end
        tick();
        tick();
        checks++;
        if (busy[2] !== 1'b0 || sent_count[2] !== 6'd1 || checksum[2] !== 32'h1111110F) begin
            errors++;
            $display("FAIL single_end: busy=%b sent=%0d chk=%h, required 0 1 1111110f",
                     busy[2], sent_count[2], checksum[2]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_dump(1'b0);
        test_full_dump(1'b1);
        test_skip_zero();
        test_hold_handshake();
        test_abort();
        test_async_reset();
        test_full_dump(1'b0);
        test_single_reg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
